// File: rtl/multi_chan_clk_div.sv
// rtl/multi_chan_clk_div.sv - multi-channel programmable clock divider
// Each channel counts falling edges up to its delay and emits a toggle clock or strobe plus a boundary tick.
module multi_chan_clk_div #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 28,
  parameter int RESET_DELAY = 50000000,
  localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk100Mhz,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_chan,
  input  logic [WIDTH-1:0]    wr_delay,
  input  logic                wr_mode,
  output logic [CHANNELS-1:0] slowClk,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] RST_DLY = WIDTH'(RESET_DELAY);

  logic [WIDTH-1:0]    cnt_q        [CHANNELS];
  logic [WIDTH-1:0]    cnt_d        [CHANNELS];
  logic [WIDTH-1:0]    act_delay_q  [CHANNELS];
  logic [WIDTH-1:0]    act_delay_d  [CHANNELS];
  logic [WIDTH-1:0]    pend_delay_q [CHANNELS];
  logic [WIDTH-1:0]    pend_delay_d [CHANNELS];
  logic [CHANNELS-1:0] act_mode_q, act_mode_d;
  logic [CHANNELS-1:0] pend_mode_q, pend_mode_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] slow_q, slow_d;
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] wr_hit;
  logic                wr_ok;

  assign wr_ok = wr_en && (32'(wr_chan) < CHANNELS);

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = wr_ok && (wr_chan == CW'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]        = cnt_q[i];
      act_delay_d[i]  = act_delay_q[i];
      act_mode_d[i]   = act_mode_q[i];
      pend_delay_d[i] = pend_delay_q[i];
      pend_mode_d[i]  = pend_mode_q[i];
      pend_d[i]       = pend_q[i];
      slow_d[i]       = slow_q[i];
      tick_d[i]       = 1'b0;

      if (!en[i]) begin
        // A stopped channel has no boundary to wait for, so new config lands now.
        if (act_mode_q[i]) slow_d[i] = 1'b0;
        if (wr_hit[i]) begin
          act_delay_d[i] = wr_delay;
          act_mode_d[i]  = wr_mode;
          cnt_d[i]       = ONE;
          pend_d[i]      = 1'b0;
        end else if (pend_q[i]) begin
          act_delay_d[i] = pend_delay_q[i];
          act_mode_d[i]  = pend_mode_q[i];
          cnt_d[i]       = ONE;
          pend_d[i]      = 1'b0;
        end
      end else if (cnt_q[i] == ((act_delay_q[i] == '0) ? ONE : act_delay_q[i])) begin
        cnt_d[i]  = ONE;
        tick_d[i] = 1'b1;
        slow_d[i] = act_mode_q[i] ? 1'b1 : ~slow_q[i];
        pend_d[i] = 1'b0;
        if (wr_hit[i]) begin
          act_delay_d[i] = wr_delay;
          act_mode_d[i]  = wr_mode;
        end else if (pend_q[i]) begin
          act_delay_d[i] = pend_delay_q[i];
          act_mode_d[i]  = pend_mode_q[i];
        end
      end else begin
        cnt_d[i] = cnt_q[i] + ONE;
        if (act_mode_q[i]) slow_d[i] = 1'b0;
        if (wr_hit[i]) begin
          pend_delay_d[i] = wr_delay;
          pend_mode_d[i]  = wr_mode;
          pend_d[i]       = 1'b1;
        end
      end
    end
  end

  always_ff @(negedge clk100Mhz) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]        <= ONE;
        act_delay_q[i]  <= RST_DLY;
        pend_delay_q[i] <= '0;
      end
      act_mode_q  <= '0;
      pend_mode_q <= '0;
      pend_q      <= '0;
      slow_q      <= '0;
      tick_q      <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]        <= cnt_d[i];
        act_delay_q[i]  <= act_delay_d[i];
        pend_delay_q[i] <= pend_delay_d[i];
      end
      act_mode_q  <= act_mode_d;
      pend_mode_q <= pend_mode_d;
      pend_q      <= pend_d;
      slow_q      <= slow_d;
      tick_q      <= tick_d;
    end
  end

  assign slowClk = slow_q;
  assign tick    = tick_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_multi_chan_clk_div.sv
// tb/tb_multi_chan_clk_div.sv - scoreboard bench for multi_chan_clk_div
// Expected outputs come from a countdown-to-boundary model and are checked by a separate monitor.
module tb_multi_chan_clk_div;

  localparam int CH = 3;
  localparam int WD = 8;
  localparam int RD = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] en = '0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_chan = '0;
  logic [WD-1:0] wr_delay = '0;
  logic          wr_mode = 1'b0;
  logic [CH-1:0] slowClk, tick, pending;

  multi_chan_clk_div #(.CHANNELS(CH), .WIDTH(WD), .RESET_DELAY(RD)) dut (
    .clk100Mhz(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_chan(wr_chan),
    .wr_delay(wr_delay), .wr_mode(wr_mode), .slowClk(slowClk), .tick(tick), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] s;
    logic [CH-1:0] t;
    logic [CH-1:0] p;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state: edges left before the boundary, configured delay/mode, queued config.
  int m_left[CH], m_dly[CH], m_pd[CH];
  bit m_mode[CH], m_pm[CH], m_pend[CH], m_slow[CH], m_tick[CH];

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic void model_step(input bit r, input bit [CH-1:0] e, input bit w,
                                     input int wc, input int wd, input bit wm);
    for (int c = 0; c < CH; c++) begin
      bit hit;
      hit = w && (wc < CH) && (wc == c);
      if (r) begin
        m_left[c] = RD - 1; m_dly[c] = RD; m_mode[c] = 0;
        m_pend[c] = 0; m_slow[c] = 0; m_tick[c] = 0;
      end else if (!e[c]) begin
        m_tick[c] = 0;
        if (m_mode[c]) m_slow[c] = 0;
        if (hit || m_pend[c]) begin
          m_dly[c]  = hit ? wd : m_pd[c];
          m_mode[c] = hit ? wm : m_pm[c];
          m_left[c] = eff(m_dly[c]) - 1;
          m_pend[c] = 0;
        end
      end else if (m_left[c] == 0) begin
        m_tick[c] = 1;
        m_slow[c] = m_mode[c] ? 1'b1 : !m_slow[c];
        if (hit) begin
          m_dly[c] = wd; m_mode[c] = wm;
        end else if (m_pend[c]) begin
          m_dly[c] = m_pd[c]; m_mode[c] = m_pm[c];
        end
        m_pend[c] = 0;
        m_left[c] = eff(m_dly[c]) - 1;
      end else begin
        m_left[c]--;
        m_tick[c] = 0;
        if (m_mode[c]) m_slow[c] = 0;
        if (hit) begin
          m_pd[c] = wd; m_pm[c] = wm; m_pend[c] = 1;
        end
      end
    end
  endfunction

  task automatic step(input bit r, input bit [CH-1:0] e, input bit w,
                      input int wc, input int wd, input bit wm);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; en = e; wr_en = w;
    wr_chan = wc[1:0]; wr_delay = wd[WD-1:0]; wr_mode = wm;
    model_step(r, e, w, wc, wd, wm);
    for (int c = 0; c < CH; c++) begin
      x.s[c] = m_slow[c]; x.t[c] = m_tick[c]; x.p[c] = m_pend[c];
    end
    exp_q.push_back(x);
  endtask

  task automatic idle(input int n, input bit [CH-1:0] e);
    for (int k = 0; k < n; k++) step(0, e, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input logic [CH-1:0] got, input logic [CH-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%b expected=%b", nm, $time, got, want);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("slowClk", slowClk, x.s);
        chk("tick", tick, x.t);
        chk("pending", pending, x.p);
      end
    end
  end

  initial begin : stim
    int guard;
    idle(0, '0);
    for (int k = 0; k < 3; k++) step(1, '1, 0, 0, 0, 0);
    idle(22, '1);
    // channel 2 to pulse mode, delay 3
    step(0, '1, 1, 2, 3, 1);
    idle(14, '1);
    // mid-period reload of channel 0
    idle(2, '1);
    step(0, '1, 1, 0, 7, 0);
    idle(20, '1);
    // last write wins on channel 1
    step(0, '1, 1, 1, 9, 0);
    step(0, '1, 1, 1, 4, 0);
    idle(14, '1);
    // write landing on the terminal edge of channel 0
    guard = 0;
    while (m_left[0] != 0 && guard < 40) begin
      idle(1, '1);
      guard++;
    end
    step(0, '1, 1, 0, 6, 0);
    idle(16, '1);
    // channel 1 disabled mid-period, reconfigured while stopped
    idle(2, '1);
    idle(4, 3'b101);
    step(0, 3'b101, 1, 1, 2, 0);
    idle(5, 3'b101);
    idle(12, '1);
    // delay 0 behaves as 1; out-of-range write is dropped
    step(0, '1, 1, 0, 0, 0);
    step(0, '1, 1, 3, 2, 1);
    idle(12, '1);
    // reset mid-period with a pending write
    step(0, '1, 1, 2, 6, 0);
    idle(1, '1);
    step(1, '1, 0, 0, 0, 0);
    idle(10, '1);
    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      bit [CH-1:0] e;
      for (int c = 0; c < CH; c++) e[c] = ($urandom_range(7) != 0);
      step(($urandom_range(63) == 0), e, ($urandom_range(3) == 0),
           $urandom_range(3), $urandom_range(6), $urandom_range(1));
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
